// File: rtl/dmem_wait_ctrl_if.sv
// dmem_wait_ctrl_if
//   CPU load/store bus between a CPU port (master) and the data-memory
//   controller (slave). The master holds req and all request fields stable
//   until it sees ready.
//
//   req    master->slave  access request
//   we     master->slave  1 = store, 0 = load
//   size   master->slave  00 byte, 01 half, 10 word, 11 illegal
//   sign   master->slave  loads only: 1 = sign-extend, 0 = zero-extend
//   addr   master->slave  absolute byte address
//   wdata  master->slave  store data, right-aligned
//   rdata  slave->master  extended load data, valid while ready=1
//   ready  slave->master  one-cycle response strobe
//   fault  slave->master  [0] misaligned/illegal size, [1] out of range
//   stall  slave->master  combinational CPU stall request
interface dmem_wait_ctrl_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sign;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic [1:0]  fault;
   logic        stall;

   modport master (
      output req, we, size, sign, addr, wdata,
      input  rdata, ready, fault, stall
   );

   modport slave (
      input  req, we, size, sign, addr, wdata,
      output rdata, ready, fault, stall
   );
endinterface

// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl
//   Data-memory controller between the CPU load/store port and a word-wide
//   data array. It relocates the CPU address by BASE_ADDR, does byte/half/word
//   loads (sign or zero extended) and stores, inserts WAIT_CYCLES wait states,
//   and reports misaligned or out-of-range accesses instead of wrapping.
//
//   clk   in     clock, all state updates on the rising edge
//   rst   in     asynchronous active-low reset (array contents are kept)
//   bus   slave  request/response bus (see dmem_wait_ctrl_if)
//
//   Latency from the accept edge: good access -> ready in cycle WAIT_CYCLES+2,
//   faulted access -> ready in cycle 1. After each response one IDLE cycle
//   passes before the next request can be accepted.
module dmem_wait_ctrl #(
   parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
   parameter int          DEPTH_WORDS = 32,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   dmem_wait_ctrl_if.slave  bus
);

   localparam int          AW       = $clog2(DEPTH_WORDS);
   localparam int          OW       = AW + 2;        // byte offset width inside the array
   localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            ready_q, ready_d;
   logic [1:0]      fault_q, fault_d;

   // Request fields captured at the accept edge; the transaction runs from
   // these so a misbehaving CPU dropping req mid-flight cannot corrupt it.
   logic            we_q;
   logic [1:0]      size_q;
   logic            sign_q;
   logic [OW-1:0]   off_q;
   logic [31:0]     wdata_q;

   logic [31:0]     off_full;
   logic            range_flt;
   logic            align_flt;
   logic            accept;

   logic [31:0]     mem_q [DEPTH_WORDS];
   logic [AW-1:0]   idx;
   logic [3:0]      be;
   logic [31:0]     wlane;
   logic            mem_we;
   logic [31:0]     rd_word;
   logic [7:0]      rd_byte;
   logic [15:0]     rd_half;
   logic [31:0]     load_val;

   // ------------------------------------------------------------------
   // Address translation and request checks (evaluated on the live bus)
   // ------------------------------------------------------------------
   // Addresses below BASE_ADDR wrap to huge offsets and so trip the range check.
   assign off_full  = bus.addr - BASE_ADDR;
   assign range_flt = (off_full >= SPAN);
   assign align_flt = (bus.size == 2'b11)
                    | ((bus.size == 2'b01) & off_full[0])
                    | ((bus.size == 2'b10) & (off_full[1:0] != 2'b00));
   assign accept    = (state_q == IDLE) & bus.req;

   // ------------------------------------------------------------------
   // Lane steering for stores
   // ------------------------------------------------------------------
   assign idx    = off_q[OW-1:2];
   assign mem_we = (state_q == ACCESS) & we_q;

   // Right-aligned store data is replicated across lanes so that whichever
   // lane(s) the byte enables pick already hold the right bytes.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign be[gi] = (size_q == 2'b10)
                    | ((size_q == 2'b01) & (off_q[1] == LANE[1]))
                    | ((size_q == 2'b00) & (off_q[1:0] == LANE));
      assign wlane[gi*8 +: 8] = (size_q == 2'b00) ? wdata_q[7:0] :
                                (size_q == 2'b01) ? wdata_q[(gi % 2)*8 +: 8] :
                                                    wdata_q[gi*8 +: 8];
   end

   // Data array: not reset. A reset during WAIT/ACCESS forces IDLE
   // asynchronously, so mem_we is already low at the following edge and the
   // pending store is dropped.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int l = 0; l < 4; l++) begin
            if (be[l]) begin
               mem_q[idx][l*8 +: 8] <= wlane[l*8 +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Load lane selection and extension
   // ------------------------------------------------------------------
   assign rd_word = mem_q[idx];
   assign rd_byte = rd_word[{off_q[1:0], 3'b000} +: 8];
   assign rd_half = off_q[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      load_val = 32'd0;
      case (size_q)
         2'b00:   load_val = sign_q ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
         2'b01:   load_val = sign_q ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
         2'b10:   load_val = rd_word;
         default: load_val = 32'd0;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: next state and registered outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      ready_d = 1'b0;
      case (state_q)
         IDLE: begin
            rdata_d = 32'd0;
            fault_d = 2'b00;
            if (bus.req) begin
               if (range_flt | align_flt) begin
                  // Faulted requests skip the array entirely.
                  state_d = RESP;
                  fault_d = {range_flt, align_flt};
                  ready_d = 1'b1;
               end else if (WAIT_CYCLES > 0) begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ACCESS;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACCESS: begin
            state_d = RESP;
            ready_d = 1'b1;
            fault_d = 2'b00;
            rdata_d = we_q ? 32'd0 : load_val;
         end
         RESP: begin
            // Any req seen here is ignored; it is picked up from IDLE.
            state_d = IDLE;
            rdata_d = 32'd0;
            fault_d = 2'b00;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         ready_q <= 1'b0;
         fault_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         fault_q <= fault_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         sign_q  <= 1'b0;
         off_q   <= '0;
         wdata_q <= 32'd0;
      end else if (accept) begin
         we_q    <= bus.we;
         size_q  <= bus.size;
         sign_q  <= bus.sign;
         off_q   <= off_full[OW-1:0];
         wdata_q <= bus.wdata;
      end
   end

   // ------------------------------------------------------------------
   // Bus outputs
   // ------------------------------------------------------------------
   assign bus.rdata = rdata_q;
   assign bus.ready = ready_q;
   assign bus.fault = fault_q;
   assign bus.stall = (bus.req & (state_q == IDLE)) | (state_q == WAIT) | (state_q == ACCESS);

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
module tb_dmem_wait_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   dmem_wait_ctrl_if b0 ();
   dmem_wait_ctrl_if b1 ();

   // Instance 0: default WAIT_CYCLES=2; instance 1: zero wait states.
   dmem_wait_ctrl #(.BASE_ADDR(32'h1001_0000), .DEPTH_WORDS(32), .WAIT_CYCLES(2)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (b0)
   );

   dmem_wait_ctrl #(.BASE_ADDR(32'h1001_0000), .DEPTH_WORDS(32), .WAIT_CYCLES(0)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic get_stall(input int inst);
      return (inst == 0) ? b0.stall : b1.stall;
   endfunction

   function automatic logic get_ready(input int inst);
      return (inst == 0) ? b0.ready : b1.ready;
   endfunction

   // Drives one request, holds it until ready, and reports the response,
   // the cycle ready appeared in (accept edge = end of cycle 0) and the
   // stall value seen in each cycle.
   task automatic do_acc(input int inst, input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic [1:0] ft,
                         output int lat, output logic [15:0] stv);
      @(negedge clk);
      if (inst == 0) begin
         b0.req = 1'b1; b0.we = w; b0.size = sz; b0.sign = sg; b0.addr = a; b0.wdata = wd;
      end else begin
         b1.req = 1'b1; b1.we = w; b1.size = sz; b1.sign = sg; b1.addr = a; b1.wdata = wd;
      end
      #1;
      stv    = '0;
      stv[0] = get_stall(inst);
      lat    = -1;
      rd     = '0;
      ft     = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c < 16) stv[c] = get_stall(inst);
         if (get_ready(inst)) begin
            lat = c;
            rd  = (inst == 0) ? b0.rdata : b1.rdata;
            ft  = (inst == 0) ? b0.fault : b1.fault;
            break;
         end
      end
      if (inst == 0) b0.req = 1'b0; else b1.req = 1'b0;
      if (lat < 0) begin
         n_checks++; n_fail++;
         $display("FAIL timeout: inst %0d addr %h got no ready within 40 cycles, required ready", inst, a);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({b0.ready, b0.fault, b0.rdata, b0.stall} !== 36'd0) begin
         n_fail++;
         $display("FAIL reset_in0: ready/fault/rdata/stall got %h required 0", {b0.ready, b0.fault, b0.rdata, b0.stall});
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({b0.ready, b0.fault, b0.rdata, b0.stall} !== 36'd0) begin
         n_fail++;
         $display("FAIL reset_out0: got %h required 0", {b0.ready, b0.fault, b0.rdata, b0.stall});
      end
      n_checks++;
      if ({b1.ready, b1.fault, b1.rdata, b1.stall} !== 36'd0) begin
         n_fail++;
         $display("FAIL reset_out1: got %h required 0", {b1.ready, b1.fault, b1.rdata, b1.stall});
      end
      $display("reset: outputs checked idle");
   endtask

   task automatic test_load_ext();
      logic [31:0] rd; logic [1:0] ft; int lat; logic [15:0] stv;
      do_acc(0, 1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'h8000_00FF, rd, ft, lat, stv);
      $display("sw   @10010004 wd=800000ff -> fault=%b lat=%0d", ft, lat);
      n_checks++;
      if (ft !== 2'b00 || lat !== 4) begin
         n_fail++; $display("FAIL sw_basic: fault/lat got %b/%0d required 00/4", ft, lat);
      end
      do_acc(0, 1'b0, 2'b00, 1'b1, 32'h1001_0004, 32'h0, rd, ft, lat, stv);
      $display("lb   @10010004 -> rdata=%h lat=%0d stall=%b", rd, lat, stv[4:0]);
      n_checks++;
      if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL lb: rdata got %h required ffffffff", rd); end
      n_checks++;
      if (lat !== 4) begin n_fail++; $display("FAIL lb_latency: got %0d required 4", lat); end
      n_checks++;
      if (stv[4:0] !== 5'b01111) begin n_fail++; $display("FAIL lb_stall: cycles4..0 got %b required 01111", stv[4:0]); end
      do_acc(0, 1'b0, 2'b00, 1'b0, 32'h1001_0004, 32'h0, rd, ft, lat, stv);
      $display("lbu  @10010004 -> rdata=%h", rd);
      n_checks++;
      if (rd !== 32'h0000_00FF) begin n_fail++; $display("FAIL lbu: rdata got %h required 000000ff", rd); end
      do_acc(0, 1'b0, 2'b01, 1'b0, 32'h1001_0006, 32'h0, rd, ft, lat, stv);
      $display("lhu  @10010006 -> rdata=%h", rd);
      n_checks++;
      if (rd !== 32'h0000_8000) begin n_fail++; $display("FAIL lhu: rdata got %h required 00008000", rd); end
      do_acc(0, 1'b0, 2'b01, 1'b1, 32'h1001_0006, 32'h0, rd, ft, lat, stv);
      $display("lh   @10010006 -> rdata=%h", rd);
      n_checks++;
      if (rd !== 32'hFFFF_8000) begin n_fail++; $display("FAIL lh: rdata got %h required ffff8000", rd); end
   endtask

   task automatic test_partial_store();
      logic [31:0] rd; logic [1:0] ft; int lat; logic [15:0] stv;
      do_acc(0, 1'b1, 2'b00, 1'b0, 32'h1001_0005, 32'h1234_56AB, rd, ft, lat, stv);
      do_acc(0, 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0, rd, ft, lat, stv);
      $display("sb ab @10010005; lw @10010004 -> rdata=%h", rd);
      n_checks++;
      if (rd !== 32'h8000_ABFF) begin n_fail++; $display("FAIL sb_lanes: rdata got %h required 8000abff", rd); end
      do_acc(0, 1'b1, 2'b01, 1'b0, 32'h1001_0006, 32'hFFFF_BEEF, rd, ft, lat, stv);
      do_acc(0, 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0, rd, ft, lat, stv);
      $display("sh beef @10010006; lw @10010004 -> rdata=%h", rd);
      n_checks++;
      if (rd !== 32'hBEEF_ABFF) begin n_fail++; $display("FAIL sh_lanes: rdata got %h required beefabff", rd); end
   endtask

   task automatic test_faults();
      logic [31:0] rd; logic [1:0] ft; int lat; logic [15:0] stv;
      do_acc(0, 1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'h0, rd, ft, lat, stv);
      $display("lw   @10010002 -> fault=%b rdata=%h lat=%0d stall=%b", ft, rd, lat, stv[1:0]);
      n_checks++;
      if (ft !== 2'b01 || rd !== 32'd0) begin n_fail++; $display("FAIL misalign_lw: fault/rdata got %b/%h required 01/0", ft, rd); end
      n_checks++;
      if (lat !== 1 || stv[1:0] !== 2'b01) begin n_fail++; $display("FAIL fault_latency: lat/stall got %0d/%b required 1/01", lat, stv[1:0]); end
      // Seed word 0 so a wrapped store to offset 0x81 would show up there.
      do_acc(0, 1'b1, 2'b10, 1'b0, 32'h1001_0000, 32'h1122_3344, rd, ft, lat, stv);
      do_acc(0, 1'b1, 2'b01, 1'b0, 32'h1001_0081, 32'h0000_AAAA, rd, ft, lat, stv);
      $display("sh   @10010081 -> fault=%b", ft);
      n_checks++;
      if (ft !== 2'b11) begin n_fail++; $display("FAIL both_faults: fault got %b required 11", ft); end
      do_acc(0, 1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0, rd, ft, lat, stv);
      $display("lw   @10010000 -> rdata=%h", rd);
      n_checks++;
      if (rd !== 32'h1122_3344) begin n_fail++; $display("FAIL fault_no_write: rdata got %h required 11223344", rd); end
      do_acc(0, 1'b0, 2'b10, 1'b0, 32'h1000_FFFC, 32'h0, rd, ft, lat, stv);
      $display("lw   @1000fffc -> fault=%b", ft);
      n_checks++;
      if (ft !== 2'b10) begin n_fail++; $display("FAIL below_base: fault got %b required 10", ft); end
      do_acc(0, 1'b0, 2'b11, 1'b0, 32'h1001_0008, 32'h0, rd, ft, lat, stv);
      $display("size11 @10010008 -> fault=%b", ft);
      n_checks++;
      if (ft !== 2'b01) begin n_fail++; $display("FAIL size_illegal: fault got %b required 01", ft); end
   endtask

   task automatic test_boundary();
      logic [31:0] rd; logic [1:0] ft; int lat; logic [15:0] stv;
      do_acc(0, 1'b1, 2'b10, 1'b0, 32'h1001_007C, 32'hCAFE_F00D, rd, ft, lat, stv);
      do_acc(0, 1'b0, 2'b10, 1'b0, 32'h1001_007C, 32'h0, rd, ft, lat, stv);
      $display("lw   @1001007c -> rdata=%h fault=%b", rd, ft);
      n_checks++;
      if (rd !== 32'hCAFE_F00D || ft !== 2'b00) begin n_fail++; $display("FAIL last_word: rdata/fault got %h/%b required cafef00d/00", rd, ft); end
      do_acc(0, 1'b0, 2'b10, 1'b0, 32'h1001_0080, 32'h0, rd, ft, lat, stv);
      $display("lw   @10010080 -> rdata=%h fault=%b", rd, ft);
      n_checks++;
      if (rd !== 32'd0 || ft !== 2'b10) begin n_fail++; $display("FAIL past_end: rdata/fault got %h/%b required 0/10", rd, ft); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic [1:0] ft; int lat; logic [15:0] stv;
      do_acc(0, 1'b1, 2'b10, 1'b0, 32'h1001_0010, 32'h0102_0304, rd, ft, lat, stv);
      @(negedge clk);
      b0.req = 1'b1; b0.we = 1'b1; b0.size = 2'b10; b0.sign = 1'b0;
      b0.addr = 32'h1001_0010; b0.wdata = 32'hDEAD_BEEF;
      @(negedge clk);                 // cycle 1: in WAIT
      b0.req = 1'b0;
      #1;
      n_checks++;
      if (b0.stall !== 1'b1) begin n_fail++; $display("FAIL mid_wait: stall got %b required 1", b0.stall); end
      rst = 1'b0;
      #1;
      n_checks++;
      if ({b0.ready, b0.fault, b0.rdata, b0.stall} !== 36'd0) begin
         n_fail++; $display("FAIL mid_reset: ready/fault/rdata/stall got %h required 0", {b0.ready, b0.fault, b0.rdata, b0.stall});
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      do_acc(0, 1'b0, 2'b10, 1'b0, 32'h1001_0010, 32'h0, rd, ft, lat, stv);
      $display("reset in WAIT; lw @10010010 -> rdata=%h", rd);
      n_checks++;
      if (rd !== 32'h0102_0304) begin n_fail++; $display("FAIL store_discard: rdata got %h required 01020304", rd); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] rd; logic [1:0] ft; int lat; logic [15:0] stv;
      do_acc(1, 1'b1, 2'b10, 1'b0, 32'h1001_0020, 32'h5A5A_1234, rd, ft, lat, stv);
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL w0_sw_latency: got %0d required 2", lat); end
      do_acc(1, 1'b0, 2'b10, 1'b0, 32'h1001_0020, 32'h0, rd, ft, lat, stv);
      $display("w0 lw @10010020 -> rdata=%h lat=%0d", rd, lat);
      n_checks++;
      if (rd !== 32'h5A5A_1234 || lat !== 2) begin n_fail++; $display("FAIL w0_lw: rdata/lat got %h/%0d required 5a5a1234/2", rd, lat); end
   endtask

   task automatic test_back_to_back();
      logic [8:0] rdy_v;
      logic [8:0] stl_v;
      @(negedge clk);
      b1.req = 1'b1; b1.we = 1'b0; b1.size = 2'b10; b1.sign = 1'b0;
      b1.addr = 32'h1001_0020; b1.wdata = 32'h0;
      #1;
      rdy_v    = '0;
      stl_v    = '0;
      rdy_v[0] = b1.ready;
      stl_v[0] = b1.stall;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         rdy_v[c] = b1.ready;
         stl_v[c] = b1.stall;
      end
      b1.req = 1'b0;
      $display("w0 back-to-back: ready cycles8..0=%b stall=%b", rdy_v, stl_v);
      n_checks++;
      if (rdy_v !== 9'b100100100) begin n_fail++; $display("FAIL b2b_ready: got %b required 100100100", rdy_v); end
      n_checks++;
      if (stl_v !== 9'b011011011) begin n_fail++; $display("FAIL b2b_stall: got %b required 011011011", stl_v); end
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      b0.req = 1'b0; b0.we = 1'b0; b0.size = 2'b00; b0.sign = 1'b0; b0.addr = '0; b0.wdata = '0;
      b1.req = 1'b0; b1.we = 1'b0; b1.size = 2'b00; b1.sign = 1'b0; b1.addr = '0; b1.wdata = '0;
      test_reset();
      test_load_ext();
      test_partial_store();
      test_faults();
      test_boundary();
      test_reset_mid();
      test_zero_wait();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
